// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives the PC load/next value and the IF/ID enable/flush.
// Define FETCH_PERF_COUNTERS_EN to add saturating fetch/stall performance counters.
module fetch_controller #(
  parameter int PC_WIDTH     = 19,
  parameter int PC_STEP      = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_detect,
  input  logic [PC_WIDTH-1:0] pc_cur,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                running,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count,
`endif
  output logic                halted
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [2:0]          FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] STEP         = PC_WIDTH'(PC_STEP);

  logic [1:0] state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  // Mealy decode: stall/branch act in the same cycle they are raised.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_next     = pc_cur;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_en       = 1'b1;
          pc_next     = branch_target;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (stall) begin
          ifid_flush = 1'b0;
        end else if (halt_detect) begin
          state_d = HALTED;
        end else begin
          pc_en      = 1'b1;
          pc_next    = pc_cur + STEP;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
        end
      end
      FLUSH: begin
        // Decode holds a squashed instruction here, so halt_detect is ignored.
        if (branch_taken) begin
          pc_en       = 1'b1;
          pc_next     = branch_target;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (!stall) begin
          pc_en       = 1'b1;
          pc_next     = pc_cur + STEP;
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) state_d = RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign running = (state_q == RUN) || (state_q == FLUSH);
  assign halted  = (state_q == HALTED);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        stall_event;

  assign stall_event = running && stall && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (ifid_en && (fetch_count_q != 32'hFFFF_FFFF))
        fetch_count_q <= fetch_count_q + 32'd1;
      if (stall_event && (stall_count_q != 32'hFFFF_FFFF))
        stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a PC flipflop model closing the loop.
// Perf-counter checks are active when FETCH_PERF_COUNTERS_EN is defined.
module tb_fetch_controller;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         reset, start, stall, branch_taken, halt_detect;
  logic [W-1:0] branch_target;
  logic [W-1:0] pc_cur, pc_next;
  logic         pc_en, ifid_en, ifid_flush, running, halted;
  logic [W-1:0] pcQ;
  logic         overrideEn;
  logic [W-1:0] overrideVal;
  int           nCompared = 0;
  int           nMismatched = 0;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]  fetch_count, stall_count;
`endif

  always #5 clk = ~clk;

  fetch_controller #(.PC_WIDTH(W), .PC_STEP(1), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_detect(halt_detect), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .running(running),
`ifdef FETCH_PERF_COUNTERS_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .halted(halted)
  );

  // PC flipflop model the controller drives; override lets us jump to the wrap point.
  always_ff @(posedge clk) begin
    if (reset) pcQ <= '0;
    else if (pc_en) pcQ <= pc_next;
  end
  assign pc_cur = overrideEn ? overrideVal : pcQ;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    halt_detect = 1'b0; branch_target = '0; overrideEn = 1'b0; overrideVal = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    #1;
    checkOutput("idle_running", 32'(running), 32'd0);
    checkOutput("idle_halted", 32'(halted), 32'd0);
    checkOutput("idle_flush", 32'(ifid_flush), 32'd1);
    checkOutput("idle_pc_en", 32'(pc_en), 32'd0);

    start = 1'b1;
    #1;
    checkOutput("start_pc_en", 32'(pc_en), 32'd0);
    tick();
    start = 1'b0;

    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("seq_pc", 32'(pc_cur), 32'(i));
      checkOutput("seq_next", 32'(pc_next), 32'(i + 1));
      checkOutput("seq_ifid_en", 32'(ifid_en), 32'd1);
      checkOutput("seq_running", 32'(running), 32'd1);
      tick();
    end
    tick();

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_pc", 32'(pc_cur), 32'h5);
      checkOutput("stall_pc_en", 32'(pc_en), 32'd0);
      checkOutput("stall_ifid_en", 32'(ifid_en), 32'd0);
      checkOutput("stall_flush", 32'(ifid_flush), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    checkOutput("post_stall_pc", 32'(pc_cur), 32'h5);
    checkOutput("post_stall_pc_en", 32'(pc_en), 32'd1);
    tick();
    checkOutput("resume_pc", 32'(pc_cur), 32'h6);
    tick(); tick();

    checkOutput("pre_branch_pc", 32'(pc_cur), 32'h8);
    branch_taken = 1'b1; branch_target = 19'h100;
    #1;
    checkOutput("br_next", 32'(pc_next), 32'h100);
    checkOutput("br_pc_en", 32'(pc_en), 32'd1);
    checkOutput("br_flush", 32'(ifid_flush), 32'd1);
    checkOutput("br_ifid_en", 32'(ifid_en), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    checkOutput("fl_pc", 32'(pc_cur), 32'h100);
    checkOutput("fl_flush", 32'(ifid_flush), 32'd1);
    checkOutput("fl_next", 32'(pc_next), 32'h101);
    checkOutput("fl_running", 32'(running), 32'd1);
    tick();
    checkOutput("after_fl_pc", 32'(pc_cur), 32'h101);
    checkOutput("after_fl_flush", 32'(ifid_flush), 32'd0);
    checkOutput("after_fl_ifid_en", 32'(ifid_en), 32'd1);
    tick();

    // Branch beats stall and halt raised in the same cycle.
    branch_taken = 1'b1; stall = 1'b1; halt_detect = 1'b1; branch_target = 19'h40;
    #1;
    checkOutput("combo_next", 32'(pc_next), 32'h40);
    checkOutput("combo_pc_en", 32'(pc_en), 32'd1);
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    #1;
    checkOutput("combo_pc", 32'(pc_cur), 32'h40);
    checkOutput("combo_halted", 32'(halted), 32'd0);
    checkOutput("fl_halt_pc_en", 32'(pc_en), 32'd1);
    checkOutput("fl_halt_flush", 32'(ifid_flush), 32'd1);
    tick();
    halt_detect = 1'b0;
    #1;
    checkOutput("no_halt_pc", 32'(pc_cur), 32'h41);
    checkOutput("no_halt_halted", 32'(halted), 32'd0);
    checkOutput("no_halt_ifid_en", 32'(ifid_en), 32'd1);

    halt_detect = 1'b1;
    #1;
    checkOutput("halt_pc_en", 32'(pc_en), 32'd0);
    checkOutput("halt_flush", 32'(ifid_flush), 32'd1);
    tick();
    halt_detect = 1'b0;
    checkOutput("halted", 32'(halted), 32'd1);
    checkOutput("halted_running", 32'(running), 32'd0);
    branch_taken = 1'b1; branch_target = 19'h200; start = 1'b1;
    #1;
    checkOutput("halted_br_pc_en", 32'(pc_en), 32'd0);
    tick();
    branch_taken = 1'b0; start = 1'b0;
    checkOutput("halted_pc_frozen", 32'(pc_cur), 32'h41);
    checkOutput("still_halted", 32'(halted), 32'd1);

    // Reset while in FLUSH drops the pending flush.
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; branch_taken = 1'b1; branch_target = 19'h10;
    tick();
    branch_taken = 1'b0;
    #1;
    checkOutput("pre_rst_flush", 32'(ifid_flush), 32'd1);
    checkOutput("pre_rst_running", 32'(running), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_flush", 32'(ifid_flush), 32'd1);
    checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checkOutput("restart_flush", 32'(ifid_flush), 32'd0);
    checkOutput("restart_ifid_en", 32'(ifid_en), 32'd1);
    overrideEn = 1'b1; overrideVal = 19'h7FFFF;
    #1;
    checkOutput("wrap_next", 32'(pc_next), 32'h0);
    checkOutput("wrap_pc_en", 32'(pc_en), 32'd1);
    overrideEn = 1'b0;

`ifdef FETCH_PERF_COUNTERS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("perf_rst_fetch", fetch_count, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    #1;
    checkOutput("perf_fetch", fetch_count, 32'd10);
    checkOutput("perf_stall", stall_count, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
